deck_dealer_ctrl: RTL and testbench

Sequencer that owns the single port of deck_memory (64x7, synchronous write, registered read). On request it loads cards 0..51, runs a Fisher-Yates shuffle driven by an internal LFSR, and then deals cards one at a time from the top of the deck. It sits between the blackjack game FSM (requester) and deck_memory (resource).

---
 rtl/deck_pkg.sv | 20 ++
 rtl/deck_dealer_ctrl_if.sv | 12 +
 rtl/deck_lfsr16.sv | 33 +++
 rtl/deck_dealer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_deck_dealer_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/deck_pkg.sv
// rtl/deck_pkg.sv - shared constants, types and LFSR step for the deck dealer
package deck_pkg;
    localparam int DECK_SIZE = 52;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 7;

    typedef logic [DATA_W-1:0] card_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        IDLE, INIT, PICK, RD_I, RD_J, CAP_J, WR_I, WR_J, READY, DEAL_RD, DEAL_CAP
    } state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction
endpackage

// File: rtl/deck_dealer_ctrl_if.sv
// rtl/deck_dealer_ctrl_if.sv - single-port deck_memory bus
interface deck_dealer_ctrl_if;
    import deck_pkg::*;

    addr_t mem_addr;
    logic  mem_wen;
    card_t mem_wdata;
    card_t mem_rdata;

    modport master (output mem_addr, output mem_wen, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_wen, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/deck_lfsr16.sv
// rtl/deck_lfsr16.sv - 16-bit Galois LFSR with advance enable
module deck_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] state
);
    import deck_pkg::*;

    logic [15:0] state_q;
    logic [15:0] state_d;

    // advance one step only when asked
    always_comb begin
        state_d = state_q;
        if (adv) begin
            state_d = lfsr_step(state_q);
        end
    end

    // state register, reloads the seed on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
endmodule

// File: rtl/deck_dealer_ctrl.sv
// rtl/deck_dealer_ctrl.sv - deck init, Fisher-Yates shuffle and deal sequencer
module deck_dealer_ctrl
    import deck_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  shuffle_req,
    input  logic  deal_req,
    output card_t card,
    output logic  card_valid,
    output logic  deal_err,
    output logic  busy,
    output addr_t cards_left,
    output logic  deck_empty,
    deck_dealer_ctrl_if.master mem
);
    localparam addr_t LAST_IDX = addr_t'(DECK_SIZE - 1);

    state_t state_q, state_d;
    addr_t  i_q, i_d;
    addr_t  j_q, j_d;
    card_t  val_i_q, val_i_d;
    card_t  val_j_q, val_j_d;
    addr_t  top_q, top_d;
    addr_t  cards_left_q, cards_left_d;
    card_t  card_q, card_d;
    logic   card_valid_q, card_valid_d;
    logic   deal_err_q, deal_err_d;

    logic                  lfsr_adv;
    logic [15:0]           lfsr_state;
    addr_t                 lfsr_pick;
    logic [15-ADDR_W:0]    lfsr_unused;

    addr_t mem_addr_c;
    logic  mem_wen_c;
    card_t mem_wdata_c;

    deck_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (lfsr_adv),
        .state (lfsr_state)
    );

    // only the low bits choose the swap partner
    assign {lfsr_unused, lfsr_pick} = lfsr_state;

    // next-state, datapath updates and memory port drive
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        val_i_d      = val_i_q;
        val_j_d      = val_j_q;
        top_d        = top_q;
        cards_left_d = cards_left_q;
        card_d       = card_q;
        card_valid_d = 1'b0;
        deal_err_d   = 1'b0;
        lfsr_adv     = 1'b0;
        mem_addr_c   = '0;
        mem_wen_c    = 1'b0;
        mem_wdata_c  = '0;
        unique case (state_q)
            IDLE: begin
                if (shuffle_req) begin
                    state_d      = INIT;
                    i_d          = '0;
                    top_d        = '0;
                    cards_left_d = '0;
                end else if (deal_req) begin
                    if (cards_left_q != '0) begin
                        state_d = DEAL_RD;
                    end else begin
                        deal_err_d = 1'b1;
                    end
                end
            end
            INIT: begin
                mem_addr_c  = i_q;
                mem_wdata_c = card_t'(i_q);
                mem_wen_c   = 1'b1;
                if (i_q == LAST_IDX) begin
                    state_d = PICK;
                end else begin
                    i_d = i_q + addr_t'(1);
                end
            end
            PICK: begin
                lfsr_adv = 1'b1;
                j_d      = lfsr_pick;
                if (lfsr_pick <= i_q) begin
                    state_d = RD_I;
                end
            end
            RD_I: begin
                mem_addr_c = i_q;
                state_d    = RD_J;
            end
            RD_J: begin
                mem_addr_c = j_q;
                val_i_d    = mem.mem_rdata;
                state_d    = CAP_J;
            end
            CAP_J: begin
                val_j_d = mem.mem_rdata;
                state_d = WR_I;
            end
            WR_I: begin
                mem_addr_c  = i_q;
                mem_wdata_c = val_j_q;
                mem_wen_c   = 1'b1;
                state_d     = WR_J;
            end
            WR_J: begin
                mem_addr_c  = j_q;
                mem_wdata_c = val_i_q;
                mem_wen_c   = 1'b1;
                i_d         = i_q - addr_t'(1);
                state_d     = (i_q == addr_t'(1)) ? READY : PICK;
            end
            READY: begin
                top_d        = '0;
                cards_left_d = addr_t'(DECK_SIZE);
                state_d      = IDLE;
            end
            DEAL_RD: begin
                mem_addr_c = top_q;
                state_d    = DEAL_CAP;
            end
            DEAL_CAP: begin
                card_d       = mem.mem_rdata;
                top_d        = top_q + addr_t'(1);
                cards_left_d = cards_left_q - addr_t'(1);
                card_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            i_q          <= '0;
            j_q          <= '0;
            val_i_q      <= '0;
            val_j_q      <= '0;
            top_q        <= '0;
            cards_left_q <= '0;
            card_q       <= '0;
            card_valid_q <= 1'b0;
            deal_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            val_i_q      <= val_i_d;
            val_j_q      <= val_j_d;
            top_q        <= top_d;
            cards_left_q <= cards_left_d;
            card_q       <= card_d;
            card_valid_q <= card_valid_d;
            deal_err_q   <= deal_err_d;
        end
    end

    assign card          = card_q;
    assign card_valid    = card_valid_q;
    assign deal_err      = deal_err_q;
    assign busy          = (state_q != IDLE);
    assign cards_left    = cards_left_q;
    assign deck_empty    = (cards_left_q == '0);
    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wen   = mem_wen_c;
    assign mem.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_deck_dealer_ctrl.sv
// tb/tb_deck_dealer_ctrl.sv - self-checking bench for deck_dealer_ctrl
module tb_deck_dealer_ctrl;
    import deck_pkg::*;

    localparam logic [15:0] SEED_A = 16'hACE1;
    localparam logic [15:0] SEED_B = 16'h1D2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n, shuffle_req, deal_req, shuffle_req_b;
    card_t card, card_b;
    logic  card_valid, deal_err, busy, card_valid_b, deal_err_b, busy_b;
    addr_t cards_left, cards_left_b;
    logic  deck_empty, deck_empty_b;

    deck_dealer_ctrl_if mif_a();
    deck_dealer_ctrl_if mif_b();

    deck_dealer_ctrl #(.LFSR_SEED(SEED_A)) dut (
        .clk(clk), .rst_n(rst_n), .shuffle_req(shuffle_req), .deal_req(deal_req),
        .card(card), .card_valid(card_valid), .deal_err(deal_err), .busy(busy),
        .cards_left(cards_left), .deck_empty(deck_empty), .mem(mif_a)
    );

    deck_dealer_ctrl #(.LFSR_SEED(SEED_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .shuffle_req(shuffle_req_b), .deal_req(1'b0),
        .card(card_b), .card_valid(card_valid_b), .deal_err(deal_err_b), .busy(busy_b),
        .cards_left(cards_left_b), .deck_empty(deck_empty_b), .mem(mif_b)
    );

    // deck_memory models: synchronous write, registered read
    logic [6:0] ram_a [64];
    logic [6:0] ram_b [64];
    card_t rd_a, rd_b;
    always @(posedge clk) begin
        if (mif_a.mem_wen) ram_a[mif_a.mem_addr] <= mif_a.mem_wdata;
        rd_a <= ram_a[mif_a.mem_addr];
        if (mif_b.mem_wen) ram_b[mif_b.mem_addr] <= mif_b.mem_wdata;
        rd_b <= ram_b[mif_b.mem_addr];
    end
    assign mif_a.mem_rdata = rd_a;
    assign mif_b.mem_rdata = rd_b;

    int checks = 0;
    int failures = 0;

    int          md [52];
    int          dealt [52];
    logic [15:0] ml_a, ml_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // textbook Fisher-Yates with rejection sampling on the low six LFSR bits
    task automatic model_shuffle(inout logic [15:0] l);
        int j;
        int t;
        for (int k = 0; k < 52; k++) md[k] = k;
        for (int i = 51; i >= 1; i--) begin
            do begin
                j = int'(l[5:0]);
                l = ref_step(l);
            end while (j > i);
            t = md[i]; md[i] = md[j]; md[j] = t;
        end
    endtask

    task automatic wait_idle(input string tag);
        int   n = 0;
        logic bad = 1'b0;
        while (busy === 1'b1 && n < 5000) begin
            if (card_valid !== 1'b0 || deal_err !== 1'b0) bad = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_done"}, busy, 0);
        chk({tag, "_quiet"}, bad, 0);
    endtask

    task automatic do_shuffle(input string tag);
        logic init_ok = 1'b1;
        int   bad = 0;
        logic [51:0] seen = '0;
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        for (int k = 0; k < 52; k++) begin
            if (mif_a.mem_wen !== 1'b1 || mif_a.mem_addr !== 6'(k) ||
                mif_a.mem_wdata !== 7'(k) || busy !== 1'b1 || card_valid !== 1'b0) init_ok = 1'b0;
            tick();
        end
        chk({tag, "_init_writes"}, init_ok, 1);
        chk({tag, "_pick_no_wen"}, mif_a.mem_wen, 0);
        wait_idle(tag);
        model_shuffle(ml_a);
        chk({tag, "_cards_left"}, cards_left, 52);
        chk({tag, "_not_empty"}, deck_empty, 0);
        for (int k = 0; k < 52; k++) begin
            if (ram_a[k] !== 7'(md[k])) bad++;
            if (ram_a[k] < 7'd52) seen[ram_a[k]] = 1'b1;
        end
        chk({tag, "_deck_vs_model"}, bad, 0);
        chk({tag, "_permutation"}, (&seen), 1);
    endtask

    task automatic deal_one(input string tag, input int exp_card, input int exp_left);
        logic early = 1'b0;
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        if (card_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
        tick();
        if (card_valid !== 1'b0) early = 1'b1;
        tick();
        chk({tag, "_early"}, early, 0);
        chk({tag, "_valid"}, card_valid, 1);
        chk({tag, "_card"}, card, exp_card);
        chk({tag, "_left"}, cards_left, exp_left);
    endtask

    initial begin
        int n;
        int diff;
        int bad;
        int off;
        int nd;
        logic [51:0] seen;

        rst_n = 1'b0; shuffle_req = 1'b0; deal_req = 1'b0; shuffle_req_b = 1'b0;
        ml_a = SEED_A; ml_b = SEED_B;

        // 1: reset values and a deal on an empty deck
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_card", card, 0);
        chk("rst_card_valid", card_valid, 0);
        chk("rst_deal_err", deal_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cards_left", cards_left, 0);
        chk("rst_deck_empty", deck_empty, 1);
        chk("rst_mem_wen", mif_a.mem_wen, 0);
        chk("rst_mem_addr", mif_a.mem_addr, 0);
        chk("rst_mem_wdata", mif_a.mem_wdata, 0);
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        chk("empty_deal_err", deal_err, 1);
        chk("empty_no_valid", card_valid, 0);
        chk("empty_no_wen", mif_a.mem_wen, 0);
        chk("empty_idle", busy, 0);
        tick();
        chk("empty_err_pulse", deal_err, 0);

        // 2: first shuffle
        do_shuffle("t2");

        // 3: deal the whole deck back-to-back, then one more
        seen = '0;
        for (int k = 0; k < 52; k++) begin
            deal_one($sformatf("t3_deal%0d", k), md[k], 51 - k);
            dealt[k] = int'(card);
            if (card < 7'd52) seen[card] = 1'b1;
        end
        chk("t3_all_distinct", (&seen), 1);
        chk("t3_empty", deck_empty, 1);
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        chk("t3_53rd_err", deal_err, 1);
        chk("t3_53rd_no_valid", card_valid, 0);
        chk("t3_53rd_card_kept", card, md[51]);
        chk("t3_53rd_left", cards_left, 0);
        tick();

        // 4: same seed after reset gives the same deck, another seed does not
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        ml_a = SEED_A; ml_b = SEED_B;
        do_shuffle("t4");
        bad = 0;
        for (int k = 0; k < 52; k++) if (ram_a[k] !== 7'(dealt[k])) bad++;
        chk("t4_repeatable", bad, 0);
        shuffle_req_b = 1'b1;
        tick();
        shuffle_req_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 5000) begin tick(); n++; end
        chk("t4_alt_done", busy_b, 0);
        chk("t4_alt_left", cards_left_b, 52);
        model_shuffle(ml_b);
        bad = 0; diff = 0;
        for (int k = 0; k < 52; k++) begin
            if (ram_b[k] !== 7'(md[k])) bad++;
            if (ram_b[k] !== ram_a[k]) diff++;
        end
        chk("t4_alt_vs_model", bad, 0);
        chk("t4_alt_differs", (diff > 0), 1);

        // 5: simultaneous requests, deal held through busy
        deal_req = 1'b1;
        do_shuffle("t5");
        tick();
        deal_req = 1'b0;
        tick();
        tick();
        chk("t5_held_valid", card_valid, 1);
        chk("t5_held_card", card, md[0]);
        chk("t5_held_left", cards_left, 51);

        // 6: reset in the middle of the shuffle, then a fresh run
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        off = int'($urandom_range(20, 60));
        repeat (52 + off) tick();
        chk("t6_mid_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_left", cards_left, 0);
        chk("t6_rst_empty", deck_empty, 1);
        chk("t6_rst_wen", mif_a.mem_wen, 0);
        chk("t6_rst_addr", mif_a.mem_addr, 0);
        chk("t6_rst_card", card, 0);
        rst_n = 1'b1;
        ml_a = SEED_A;
        tick();
        do_shuffle("t6");
        nd = int'($urandom_range(3, 8));
        for (int k = 0; k < nd; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            deal_one($sformatf("t6_deal%0d", k), md[k], 51 - k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
